tpu_tile_sequencer: RTL and testbench
=====================================

TPU_TILE_SEQUENCER -- requirements
Module: tpu_tile_sequencer

Interface
Parameters (name, default, meaning):
REQ-001 SHALL have MATRIX_SIZE, 8, systolic array dimension (PEs per row/column).
REQ-002 SHALL have ADDRESSSIZE, 10, unified-buffer address width.
REQ-003 SHALL have ROWCNT_BW, 8, width of row-count operand.
REQ-004 SHALL have PIPE_LAT, 2*MATRIX_SIZE+1, cycles from UB read issue to array result valid (≥1).

Ports (name, direction, width, meaning):
REQ-005 SHALL have clk, in, 1, single clock; one clock; all state updates on rising edge.
REQ-006 SHALL have rst, in, 1, reset; synchronous, active-high.
REQ-007 SHALL have start, in, 1, begin tile job; sampled only in IDLE.
REQ-008 SHALL have abort, in, 1, cancel job; return to IDLE next cycle.
REQ-009 SHALL have src_base, in, ADDRESSSIZE, first UB read address; captured on accepted start.
REQ-010 SHALL have dst_base, in, ADDRESSSIZE, first result write address; captured on accepted start.
REQ-011 SHALL have num_rows, in, ROWCNT_BW, input row vectors to stream; captured on accepted start.
REQ-012 SHALL have fifo_empty, in, 1, weight FIFO empty flag.
REQ-013 SHALL have fifo_rd_en, out, 1, weight FIFO pop strobe.
REQ-014 SHALL have we_rl, out, 1, systolic weight-reload strobe.
REQ-015 SHALL have ub_rd_en / ub_rd_addr, out, 1 / ADDRESSSIZE, UB read strobe and address.
REQ-016 SHALL have out_valid / out_addr, out, 1 / ADDRESSSIZE, result-capture strobe and destination address.
REQ-017 SHALL have busy, done, out, 1 each, job active / one-cycle completion pulse.

Function
REQ-018 SHALL implement states IDLE, WLOAD, WSET, STREAM, DRAIN, DONE.
REQ-019 IDLE: start=1 SHALL capture operands and go to WLOAD; if num_rows=0, SHALL go directly to DONE with no FIFO pop or UB read.
REQ-020 WLOAD: fifo_empty=0 SHALL assert fifo_rd_en for exactly that cycle and go to WSET; fifo_empty=1 SHALL hold WLOAD indefinitely with fifo_rd_en=0.
REQ-021 WSET: SHALL assert we_rl for exactly one cycle and go to STREAM.
REQ-022 STREAM: SHALL assert ub_rd_en every cycle with ub_rd_addr=src_base+k for k=0..num_rows-1, then go to DRAIN.
REQ-023 Address arithmetic SHALL be modulo 2^ADDRESSSIZE (wrap from max to 0, no error).
REQ-024 out_valid SHALL assert exactly PIPE_LAT cycles after each ub_rd_en cycle, via a PIPE_LAT-deep valid shift register.
REQ-025 out_addr SHALL equal dst_base+j for the j-th out_valid (j from 0), wrapping per REQ-023.
REQ-026 DRAIN: SHALL go to DONE in the cycle after the num_rows-th out_valid.
REQ-027 DONE: done=1 for one cycle, then IDLE; done SHALL NOT assert on abort.
REQ-028 busy SHALL be 1 in all states except IDLE.
REQ-029 start outside IDLE SHALL be ignored; operands SHALL NOT change mid-job.
REQ-030 abort SHALL take priority over all transitions: IDLE next cycle, valid pipeline cleared, no further out_valid; abort and start in the same IDLE cycle SHALL remain in IDLE.
REQ-031 All outputs except ub_rd_addr/out_addr SHALL be 0 in cycles not listed above.

Reset
REQ-032 rst=1 SHALL force IDLE, clear the valid pipeline and counters, and drive all outputs to 0 on the next edge, including mid-job.
REQ-033 rst SHALL override abort and start.

Verification
REQ-034 MATRIX_SIZE=8, PIPE_LAT=17, fifo non-empty, start with src=0x010, dst=0x200, rows=3 -> fifo_rd_en 1 cycle, we_rl 1 cycle, ub_rd 0x010..0x012, out_valid 0x200..0x202 at 17 cycles after each read, single done pulse.
REQ-035 fifo_empty=1 for 5 cycles after start -> WLOAD held 5 cycles, no fifo_rd_en; pop on the 6th cycle; rest per REQ-034.
REQ-036 src=0x3FE, dst=0x3FF, rows=3 -> reads 0x3FE, 0x3FF, 0x000; writes 0x3FF, 0x000, 0x001.
REQ-037 rows=0 -> no fifo_rd_en, ub_rd_en, or out_valid; done one cycle after start.
REQ-038 abort 2 cycles into DRAIN with rows=4 -> IDLE next cycle, no out_valid afterwards, done never asserted; a new start then completes normally.
REQ-039 rst pulse mid-STREAM -> all outputs 0 next cycle, busy=0, a second start behaves per REQ-034.

Source files
------------

// File: rtl/tpu_tile_sequencer.sv
// tpu_tile_sequencer: weight load, row streaming and result-capture sequencing for one systolic tile job
module tpu_tile_sequencer #(
  parameter int MATRIX_SIZE = 8,
  parameter int ADDRESSSIZE = 10,
  parameter int ROWCNT_BW   = 8,
  parameter int PIPE_LAT    = 2*MATRIX_SIZE+1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDRESSSIZE-1:0] src_base,
  input  logic [ADDRESSSIZE-1:0] dst_base,
  input  logic [ROWCNT_BW-1:0]   num_rows,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  output logic                   we_rl,
  output logic                   ub_rd_en,
  output logic [ADDRESSSIZE-1:0] ub_rd_addr,
  output logic                   out_valid,
  output logic [ADDRESSSIZE-1:0] out_addr,
  output logic                   busy,
  output logic                   done
);
  typedef enum logic [2:0] {IDLE, WLOAD, WSET, STREAM, DRAIN, DONE} state_t;
  state_t                 r_state;
  logic [ADDRESSSIZE-1:0] r_src, r_dst;
  logic [ROWCNT_BW-1:0]   r_rows, r_rd_cnt, r_out_cnt;
  logic [PIPE_LAT-1:0]    r_pipe;
  logic                   w_last_rd, w_last_out;
  assign w_last_rd  = r_rd_cnt == r_rows - ROWCNT_BW'(1);
  assign w_last_out = r_out_cnt == r_rows - ROWCNT_BW'(1);
  // The pop is combinational so it lands in the very cycle the FIFO reports data
  assign fifo_rd_en = r_state == WLOAD && !fifo_empty && !abort && !rst;
  assign we_rl      = r_state == WSET;
  assign ub_rd_en   = r_state == STREAM;
  assign ub_rd_addr = r_src + ADDRESSSIZE'(r_rd_cnt);
  assign out_valid  = r_pipe[PIPE_LAT-1];
  assign out_addr   = r_dst + ADDRESSSIZE'(r_out_cnt);
  assign busy       = r_state != IDLE;
  assign done       = r_state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_src     <= '0;
      r_dst     <= '0;
      r_rows    <= '0;
      r_rd_cnt  <= '0;
      r_out_cnt <= '0;
      r_pipe    <= '0;
    end else if (abort) begin
      r_state   <= IDLE;
      r_rd_cnt  <= '0;
      r_out_cnt <= '0;
      r_pipe    <= '0;
    end else begin
      r_pipe <= (r_pipe << 1) | PIPE_LAT'(ub_rd_en);
      if (out_valid) r_out_cnt <= r_out_cnt + ROWCNT_BW'(1);
      case (r_state)
        IDLE: if (start) begin
          r_src     <= src_base;
          r_dst     <= dst_base;
          r_rows    <= num_rows;
          r_rd_cnt  <= '0;
          r_out_cnt <= '0;
          r_state   <= num_rows == '0 ? DONE : WLOAD;
        end
        WLOAD:  r_state <= fifo_empty ? WLOAD : WSET;
        WSET:   r_state <= STREAM;
        STREAM: begin
          r_rd_cnt <= w_last_rd ? '0 : r_rd_cnt + ROWCNT_BW'(1);
          r_state  <= w_last_rd ? DRAIN : STREAM;
        end
        DRAIN:   r_state <= out_valid && w_last_out ? DONE : DRAIN;
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// tb_tpu_tile_sequencer: directed jobs with a scoreboard of expected strobe events checked by a monitor
module tb_tpu_tile_sequencer;
  localparam int LAT = 17;
  logic       clk = 0, rst = 1, start = 0, abort = 0, fifo_empty = 0;
  logic [9:0] src_base = '0, dst_base = '0;
  logic [7:0] num_rows = '0;
  logic       fifo_rd_en, we_rl, ub_rd_en, out_valid, busy, done;
  logic [9:0] ub_rd_addr, out_addr;
  int cyc = 0;
  int n_tests = 0, n_fail = 0;
  typedef struct {int k; int c; logic [9:0] a;} ev_t;
  ev_t q[$];
  string nm[5] = '{"fifo_rd_en", "we_rl", "ub_rd", "out_valid", "done"};

  tpu_tile_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .src_base(src_base), .dst_base(dst_base), .num_rows(num_rows),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .we_rl(we_rl),
    .ub_rd_en(ub_rd_en), .ub_rd_addr(ub_rd_addr),
    .out_valid(out_valid), .out_addr(out_addr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", n, act, exp);
    end
  endtask

  task automatic push(input int k, input int c, input logic [9:0] a);
    ev_t e;
    e.k = k; e.c = c; e.a = a;
    q.push_back(e);
  endtask

  task automatic mon(input int k, input logic s, input logic [9:0] a);
    ev_t e;
    if (s === 1'b1) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected %s at cycle %0d addr %h, required none", nm[k], cyc, a);
      end else begin
        e = q.pop_front();
        if (e.k != k || e.c != cyc || ((k == 2 || k == 3) && e.a !== a)) begin
          n_fail++;
          $display("FAIL %s: got %s cycle %0d addr %h, required %s cycle %0d addr %h",
                   nm[k], nm[k], cyc, a, nm[e.k], e.c, e.a);
        end
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    #1;
    mon(0, fifo_rd_en, '0);
    mon(1, we_rl, '0);
    mon(2, ub_rd_en, ub_rd_addr);
    mon(3, out_valid, out_addr);
    mon(4, done, '0);
  end

  // Issues start and queues the hand-derived strobe timeline relative to the start cycle
  task automatic issue(input logic [9:0] s, input logic [9:0] d, input int n,
                       input int stall, input int nrd, input bit full);
    int t0, b;
    t0 = cyc;
    src_base = s; dst_base = d; num_rows = 8'(n);
    start = 1; fifo_empty = stall != 0;
    if (n == 0) push(4, t0 + 1, '0);
    else begin
      b = t0 + 1 + stall;
      push(0, b, '0);
      push(1, b + 1, '0);
      for (int k = 0; k < nrd; k++) push(2, b + 2 + k, s + 10'(k));
      if (full) begin
        for (int k = 0; k < n; k++) push(3, b + 2 + k + LAT, d + 10'(k));
        push(4, b + n + LAT + 2, '0);
      end
    end
    @(negedge clk);
    start = 0;
    if (stall != 0) begin
      repeat (stall) @(negedge clk);
      fifo_empty = 0;
    end
  endtask

  task automatic drain();
    int w = 0;
    while (q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: %0d events pending, required 0", q.size());
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_idle(input string p);
    chk({p, "_busy"}, 32'(busy), 0);
    chk({p, "_done"}, 32'(done), 0);
    chk({p, "_fifo_rd_en"}, 32'(fifo_rd_en), 0);
    chk({p, "_we_rl"}, 32'(we_rl), 0);
    chk({p, "_ub_rd_en"}, 32'(ub_rd_en), 0);
    chk({p, "_out_valid"}, 32'(out_valid), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst = 0;
    @(negedge clk);
    issue(10'h010, 10'h200, 3, 0, 3, 1);
    repeat (3) @(negedge clk);
    chk("midjob_busy", 32'(busy), 1);
    start = 1; src_base = 10'h100; dst_base = 10'h111; num_rows = 8'd9;
    @(negedge clk);
    start = 0;
    drain();
    issue(10'h010, 10'h200, 3, 5, 3, 1);
    drain();
    issue(10'h3FE, 10'h3FF, 3, 0, 3, 1);
    drain();
    issue(10'h055, 10'h066, 0, 0, 0, 1);
    chk("rows0_busy", 32'(busy), 1);
    drain();
    start = 1; abort = 1;
    @(negedge clk);
    start = 0; abort = 0;
    chk("start_abort_busy", 32'(busy), 0);
    drain();
    issue(10'h020, 10'h300, 4, 0, 4, 0);
    repeat (8) @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_busy", 32'(busy), 0);
    repeat (30) @(negedge clk);
    drain();
    issue(10'h030, 10'h310, 2, 0, 2, 1);
    drain();
    issue(10'h040, 10'h320, 3, 0, 2, 0);
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk_idle("midrst");
    repeat (30) @(negedge clk);
    drain();
    issue(10'h010, 10'h200, 3, 0, 3, 1);
    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
